// File: rtl/mem_port_arbiter_if.sv
// Bundle of request, response and memory-side signals between the IF/MEM
// stages, the arbiter and MainMemory. The arbiter connects through the slave
// modport. The master modport is the view of the stages and the memory model.

`ifndef WORD
`define WORD 32
`endif

interface mem_port_arbiter_if #(
  parameter int WIDTH = `WORD
);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             mem_req;
  logic             mem_w;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] st_data;
  logic             if_ack;
  logic [WIDTH-1:0] if_rdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic             stall_if;
  logic             stall_mem;
  logic             ram_we;
  logic [WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  modport master (
    output if_req, if_addr, mem_req, mem_w, mem_addr, st_data, ram_rdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata, stall_if, stall_mem,
           ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_w, mem_addr, st_data, ram_rdata,
    output if_ack, if_rdata, mem_ack, mem_rdata, stall_if, stall_mem,
           ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported MainMemory between instruction fetch (IF) and data
// access (MEM). Each access moves through IDLE -> ACCESS -> DONE.
// MEM normally wins arbitration. IF is forced through after STARVE_MAX
// back-to-back MEM grants that it has been waiting behind.

module mem_port_arbiter #(
  parameter int WIDTH      = `WORD,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    starve;
  logic             owner_if;
  logic             lat_we;
  logic             any_req;
  logic             grant_if;
  logic [WIDTH-1:0] rd_word;

  assign rd_word = bus.ram_rdata;

  // Stalls track the live request against the registered ack pulse.
  assign bus.stall_if  = bus.if_req & ~bus.if_ack;
  assign bus.stall_mem = bus.mem_req & ~bus.mem_ack;

  // Arbitration: IF wins when it is alone or when it has been starved long enough.
  always_comb begin
    any_req  = bus.if_req | bus.mem_req;
    grant_if = bus.if_req & (~bus.mem_req | (starve == STARVE_LIM));
  end

  // Access sequencer and starvation tracking, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      starve        <= '0;
      owner_if      <= 1'b0;
      lat_we        <= 1'b0;
      bus.if_ack    <= 1'b0;
      bus.mem_ack   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else begin
      if (!bus.if_req) begin
        starve <= '0;
      end else if (state == IDLE && any_req) begin
        if (grant_if) begin
          starve <= '0;
        end else if (starve != STARVE_LIM) begin
          starve <= starve + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          bus.if_ack  <= 1'b0;
          bus.mem_ack <= 1'b0;
          bus.ram_we  <= 1'b0;
          if (any_req) begin
            owner_if     <= grant_if;
            lat_we       <= ~grant_if & bus.mem_w;
            bus.ram_we   <= ~grant_if & bus.mem_w;
            bus.ram_addr <= grant_if ? bus.if_addr : bus.mem_addr;
            if (!grant_if) begin
              bus.ram_wdata <= bus.st_data;
            end
            cnt   <= CW'(MEM_LAT - 1);
            state <= ACCESS;
          end
        end

        ACCESS: begin
          bus.ram_we <= 1'b0;
          if (cnt == '0) begin
            if (owner_if) begin
              bus.if_rdata <= rd_word;
              bus.if_ack   <= 1'b1;
            end else begin
              if (!lat_we) begin
                bus.mem_rdata <= rd_word;
              end
              bus.mem_ack <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          bus.if_ack  <= 1'b0;
          bus.mem_ack <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. dut_a runs with MEM_LAT=1 and dut_b
// with MEM_LAT=3. Each DUT has its own behavioural MainMemory.

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic preload;

  int vectors     = 0;
  int miscompares = 0;
  int we_a, we_b, ack_if_a, ack_mem_a, ack_mem_b;
  logic order[$];

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  mem_port_arbiter_if #(.WIDTH(32)) bus_a ();
  mem_port_arbiter_if #(.WIDTH(32)) bus_b ();

  mem_port_arbiter #(.WIDTH(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );

  mem_port_arbiter #(.WIDTH(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  // 10-unit clock, rising edge active.
  always #5 clk = ~clk;

  assign bus_a.ram_rdata = mem_a[bus_a.ram_addr[7:0]];
  assign bus_b.ram_rdata = mem_b[bus_b.ram_addr[7:0]];

  // MainMemory models: preload known contents, then write on ram_we.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 32'h0BAD0000 | i;
        mem_b[i] <= 32'h0BAD0000 | i;
      end
      mem_a[8'h10] <= 32'hDEADBEEF;
      mem_b[8'h40] <= 32'hCAFEF00D;
    end else begin
      if (bus_a.ram_we) mem_a[bus_a.ram_addr[7:0]] <= bus_a.ram_wdata;
      if (bus_b.ram_we) mem_b[bus_b.ram_addr[7:0]] <= bus_b.ram_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit sel_b, input logic ifr, input logic memr, input logic w,
                               input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] sd);
    if (!sel_b) begin
      bus_a.if_req = ifr; bus_a.mem_req = memr; bus_a.mem_w = w;
      bus_a.if_addr = ia; bus_a.mem_addr = ma; bus_a.st_data = sd;
    end else begin
      bus_b.if_req = ifr; bus_b.mem_req = memr; bus_b.mem_w = w;
      bus_b.if_addr = ia; bus_b.mem_addr = ma; bus_b.st_data = sd;
    end
  endtask

  task automatic clearCounts();
    we_a = 0; we_b = 0; ack_if_a = 0; ack_mem_a = 0; ack_mem_b = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus_a.ram_we) we_a++;
    if (bus_b.ram_we) we_b++;
    if (bus_a.if_ack) begin ack_if_a++; order.push_back(1'b1); end
    if (bus_a.mem_ack) begin ack_mem_a++; order.push_back(1'b0); end
    if (bus_b.mem_ack) ack_mem_b++;
  endtask

  initial begin
    preload = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;

    $display("[TB] reset and idle");
    clearCounts();
    repeat (5) tick();
    checkOutput("rst_flags", 32'({bus_a.if_ack, bus_a.mem_ack, bus_a.ram_we, bus_a.stall_if, bus_a.stall_mem}), 0);
    checkOutput("rst_if_rdata", bus_a.if_rdata, 0);
    checkOutput("rst_mem_rdata", bus_a.mem_rdata, 0);
    checkOutput("rst_ram_addr", bus_a.ram_addr, 0);
    checkOutput("rst_ram_wdata", bus_a.ram_wdata, 0);
    checkOutput("rst_we_cnt", we_a, 0);
    checkOutput("rst_b_flags", 32'({bus_b.mem_ack, bus_b.ram_we, bus_b.ram_addr[0]}), 0);

    $display("[TB] IF read latency");
    applyStimulus(0, 1, 0, 0, 32'h10, 0, 0);
    #1;
    checkOutput("if_stall_t0", bus_a.stall_if, 1);
    tick();
    checkOutput("if_ack_t1", bus_a.if_ack, 0);
    checkOutput("if_stall_t1", bus_a.stall_if, 1);
    checkOutput("if_ram_addr", bus_a.ram_addr, 32'h10);
    tick();
    checkOutput("if_ack_t2", bus_a.if_ack, 1);
    checkOutput("if_rdata", bus_a.if_rdata, 32'hDEADBEEF);
    checkOutput("if_stall_t2", bus_a.stall_if, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("if_ack_drop", bus_a.if_ack, 0);
    checkOutput("if_rdata_hold", bus_a.if_rdata, 32'hDEADBEEF);

    $display("[TB] store then load");
    clearCounts();
    applyStimulus(0, 0, 1, 1, 0, 32'h20, 32'h1234);
    tick();
    checkOutput("st_ram_we", bus_a.ram_we, 1);
    checkOutput("st_ram_wdata", bus_a.ram_wdata, 32'h1234);
    tick();
    checkOutput("st_ack", bus_a.mem_ack, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("st_we_cnt", we_a, 1);
    checkOutput("st_ack_cnt", ack_mem_a, 1);
    checkOutput("st_mem_rdata_hold", bus_a.mem_rdata, 0);
    checkOutput("st_ram_content", mem_a[8'h20], 32'h1234);
    applyStimulus(0, 0, 1, 0, 0, 32'h20, 0);
    tick();
    checkOutput("ld_ram_we", bus_a.ram_we, 0);
    tick();
    checkOutput("ld_ack", bus_a.mem_ack, 1);
    checkOutput("ld_mem_rdata", bus_a.mem_rdata, 32'h1234);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] starvation order");
    clearCounts();
    order.delete();
    applyStimulus(0, 1, 1, 0, 32'h10, 32'h20, 0);
    for (int k = 0; k < 60 && order.size() < 10; k++) tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    checkOutput("starve_len", order.size(), 10);
    for (int i = 0; i < 10; i++) begin
      logic got;
      got = (i < order.size()) ? order[i] : 1'bx;
      checkOutput($sformatf("starve_order_%0d", i), 32'(got), 32'((i % 5) == 4));
    end
    checkOutput("starve_if_cnt", ack_if_a, 2);

    $display("[TB] reset during access");
    clearCounts();
    applyStimulus(1, 0, 1, 1, 0, 32'h50, 32'h5555);
    tick();
    checkOutput("abort1_we_before", bus_b.ram_we, 1);
    rst_b = 1'b1;
    #1;
    checkOutput("abort1_we_async", bus_b.ram_we, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    rst_b = 1'b0;
    repeat (6) tick();
    checkOutput("abort1_no_ack", ack_mem_b, 0);
    checkOutput("abort1_no_write", mem_b[8'h50], 32'h0BAD0050);

    applyStimulus(1, 0, 1, 0, 0, 32'h40, 0);
    tick();
    tick();
    rst_b = 1'b1;
    #1;
    checkOutput("abort2_flags", 32'({bus_b.ram_we, bus_b.mem_ack}), 0);
    checkOutput("abort2_ram_addr", bus_b.ram_addr, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    rst_b = 1'b0;
    clearCounts();
    repeat (6) tick();
    checkOutput("abort2_no_ack", ack_mem_b, 0);
    checkOutput("abort2_rdata", bus_b.mem_rdata, 0);

    applyStimulus(1, 0, 1, 0, 0, 32'h40, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("reissue_ack_t%0d", k), bus_b.mem_ack, 32'(k == 4));
    end
    checkOutput("reissue_rdata", bus_b.mem_rdata, 32'hCAFEF00D);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] request dropped mid-access");
    clearCounts();
    applyStimulus(1, 0, 1, 1, 0, 32'h60, 32'hA5A5A5A5);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    checkOutput("drop_ack_cnt", ack_mem_b, 1);
    checkOutput("drop_we_cnt", we_b, 1);
    checkOutput("drop_ram_content", mem_b[8'h60], 32'hA5A5A5A5);
    checkOutput("drop_rdata_hold", bus_b.mem_rdata, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
